// File: rtl/compress_reader.sv
// compress_reader
//
// Streams the CKKS slot words out of the two FFT BRAM banks once the
// inverse-embedding FFT has finished. Slots are visited in the order of the
// powers of 3 modulo M. Each position is mapped to its bit-reversed FFT index,
// and the non-conjugate entry is read from the bank that owns that index. Words
// leave through a valid/ready stream that supports backpressure.
//
// Ports:
//   clk, rst                    clock and asynchronous active-high reset
//   start, current_n            one-cycle launch request; ring size sampled at start
//   busy, done                  run in progress; one-cycle pulse after the final word
//   rd_addr_bank0/1, rd_en_*    BRAM read side (at most one enable per cycle)
//   rd_data_bank0/1             BRAM read data, valid RD_LATENCY cycles after rd_en
//   out_data/index/last         slot word, its slot number, and a final-word flag
//   out_valid, out_ready        stream handshake

`ifndef OVERALL_BITS
`define OVERALL_BITS 32
`endif

module compress_reader #(
  parameter int LOGN       = 13,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [1:0]                   current_n,
  output logic                         busy,
  output logic                         done,
  output logic [LOGN-2:0]              rd_addr_bank0,
  output logic [LOGN-2:0]              rd_addr_bank1,
  output logic                         rd_en_bank0,
  output logic                         rd_en_bank1,
  input  logic [2*`OVERALL_BITS-1:0]   rd_data_bank0,
  input  logic [2*`OVERALL_BITS-1:0]   rd_data_bank1,
  output logic [2*`OVERALL_BITS-1:0]   out_data,
  output logic [LOGN-1:0]              out_index,
  output logic                         out_last,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int LOGM = LOGN + 1;
  localparam int DW   = 2 * `OVERALL_BITS;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t          state, state_next;
  logic [1:0]      n_reg;
  logic [1:0]      n_sel;
  logic [LOGM-1:0] pos;
  logic [LOGM-1:0] pos_x3;
  logic [LOGM-1:0] pos_mask;
  logic [LOGM-1:0] pos_next;
  logic [LOGN-1:0] t;
  logic [LOGN-1:0] idx;
  logic            rd_bank;
  logic [LOGN-2:0] rd_addr;
  logic [LOGN-1:0] issued;
  logic [LOGN-1:0] last_slot;
  logic            is_last;
  logic            issue;
  logic [CW-1:0]   used;

  // Read pipeline side-band, one stage per cycle of BRAM latency
  logic [RD_LATENCY-1:0] pipe_valid;
  logic [RD_LATENCY-1:0] pipe_bank;
  logic [RD_LATENCY-1:0] pipe_last;
  logic [LOGN-1:0]       pipe_slot [RD_LATENCY];

  // Output FIFO
  logic [DW-1:0]   fifo_data [FIFO_DEPTH];
  logic [LOGN-1:0] fifo_slot [FIFO_DEPTH];
  logic            fifo_last [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   fifo_count;
  logic            push, pop;
  logic [DW-1:0]   push_data;

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
    logic [LOGN-1:0] r;
    for (int i = 0; i < LOGN; i++) r[i] = v[LOGN-1-i];
    return r;
  endfunction

  // Slot position to bank/address. For the smaller rings the bit-reversed index
  // is shifted down because the active FFT occupies the low part of the space.
  // The modulo-M_eff multiply by 3 is a shift-add followed by a mask.
  always_comb begin
    n_sel     = (current_n == 2'd3) ? 2'd2 : current_n;
    t         = LOGN'((pos - 1'b1) >> 1);
    idx       = bitrev(t) >> (2'd2 - n_reg);
    rd_bank   = idx[0];
    rd_addr   = idx[LOGN-1:1];
    pos_x3    = {pos[LOGM-2:0], 1'b0} + pos;
    pos_mask  = {LOGM{1'b1}} >> (2'd2 - n_reg);
    pos_next  = pos_x3 & pos_mask;
    last_slot = {LOGN{1'b1}} >> (3'd3 - {1'b0, n_reg});
    is_last   = (issued == last_slot);
  end

  // A read is allowed only while its word is guaranteed a FIFO slot: 'used'
  // counts reads in flight plus words buffered, so the FIFO can never overflow.
  always_comb begin
    issue         = (state == ISSUE) && (used < CW'(FIFO_DEPTH)) && (issued <= last_slot);
    rd_en_bank0   = issue && !rd_bank;
    rd_en_bank1   = issue && rd_bank;
    rd_addr_bank0 = (issue && !rd_bank) ? rd_addr : '0;
    rd_addr_bank1 = (issue && rd_bank) ? rd_addr : '0;
    busy          = (state != IDLE);
  end

  // FIFO head drives the stream; outputs are zeroed while empty
  always_comb begin
    out_valid = (fifo_count != '0);
    out_data  = out_valid ? fifo_data[rd_ptr] : '0;
    out_index = out_valid ? fifo_slot[rd_ptr] : '0;
    out_last  = out_valid ? fifo_last[rd_ptr] : 1'b0;
    pop       = out_valid && out_ready;
    push      = pipe_valid[RD_LATENCY-1];
    push_data = pipe_bank[RD_LATENCY-1] ? rd_data_bank1 : rd_data_bank0;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: a run ends when the final word is accepted downstream
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ISSUE;
      ISSUE:   if (issue && is_last) state_next = DRAIN;
      DRAIN:   if (pop && out_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Run bookkeeping: ring size, position walk, issue count, credits and done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_reg  <= 2'd2;
      pos    <= LOGM'(1);
      issued <= '0;
      used   <= '0;
      done   <= 1'b0;
    end else begin
      done <= (state == DRAIN) && pop && out_last;
      used <= used + CW'(issue) - CW'(pop);
      if (state == IDLE && start) begin
        n_reg  <= n_sel;
        pos    <= LOGM'(1);
        issued <= '0;
      end else if (issue) begin
        pos    <= pos_next;
        issued <= issued + 1'b1;
      end
    end
  end

  // Side-band shift register that lines each read up with its returning data.
  // Reset clears the valid bits so data still in flight is discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_valid <= '0;
      pipe_bank  <= '0;
      pipe_last  <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_slot[i] <= '0;
    end else begin
      pipe_valid[0] <= issue;
      pipe_bank[0]  <= rd_bank;
      pipe_last[0]  <= is_last;
      pipe_slot[0]  <= issued;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_bank[i]  <= pipe_bank[i-1];
        pipe_last[i]  <= pipe_last[i-1];
        pipe_slot[i]  <= pipe_slot[i-1];
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage has no reset; the outputs are masked while it is empty
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= push_data;
      fifo_slot[wr_ptr] <= pipe_slot[RD_LATENCY-1];
      fifo_last[wr_ptr] <= pipe_last[RD_LATENCY-1];
    end
  end

  // Three has order M/4 modulo a power of two, so the final advance must land on 1
  property p_pos_wraps;
    @(posedge clk) disable iff (rst) (issue && is_last) |-> (pos_next == LOGM'(1));
  endproperty
  assert property (p_pos_wraps);

endmodule

// File: tb/tb_compress_reader.sv
// tb_compress_reader
//
// Directed bench for compress_reader. Each BRAM bank is modelled as a two-stage
// read pipeline whose data is a tag naming the bank and address. Expected words
// are rebuilt from the slot order (powers of 3), the bit reversal and that tag.

`ifndef OVERALL_BITS
`define OVERALL_BITS 32
`endif

module tb_compress_reader;

  localparam int LOGN       = 13;
  localparam int LOGM       = LOGN + 1;
  localparam int RD_LATENCY = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int DW         = 2 * `OVERALL_BITS;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [1:0]      current_n;
  logic            busy, done;
  logic [LOGN-2:0] rd_addr_bank0, rd_addr_bank1;
  logic            rd_en_bank0, rd_en_bank1;
  logic [DW-1:0]   rd_data_bank0, rd_data_bank1;
  logic [DW-1:0]   out_data;
  logic [LOGN-1:0] out_index;
  logic            out_last, out_valid, out_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  compress_reader #(
    .LOGN(LOGN), .RD_LATENCY(RD_LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .current_n(current_n),
    .busy(busy), .done(done),
    .rd_addr_bank0(rd_addr_bank0), .rd_addr_bank1(rd_addr_bank1),
    .rd_en_bank0(rd_en_bank0), .rd_en_bank1(rd_en_bank1),
    .rd_data_bank0(rd_data_bank0), .rd_data_bank1(rd_data_bank1),
    .out_data(out_data), .out_index(out_index), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  function automatic logic [DW-1:0] tag(input logic b, input logic [LOGN-2:0] a);
    return DW'({16'hBEEF, 15'd0, b, 20'd0, a});
  endfunction

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
    logic [LOGN-1:0] r;
    for (int i = 0; i < LOGN; i++) r[i] = v[LOGN-1-i];
    return r;
  endfunction

  function automatic logic [DW-1:0] model_word(input int n, input int pos);
    logic [LOGM-1:0] p;
    logic [LOGN-1:0] tt, ix;
    p  = LOGM'(pos) - LOGM'(1);
    tt = p[LOGM-1:1];
    ix = bitrev(tt) >> (2 - n);
    return tag(ix[0], ix[LOGN-1:1]);
  endfunction

  // BRAM models: address captured at one edge, tagged data presented after the next
  logic [LOGN-2:0] b0_addr_q, b1_addr_q;
  logic            b0_en_q, b1_en_q;
  always @(posedge clk) begin
    b0_en_q       <= rd_en_bank0;
    b0_addr_q     <= rd_addr_bank0;
    b1_en_q       <= rd_en_bank1;
    b1_addr_q     <= rd_addr_bank1;
    rd_data_bank0 <= b0_en_q ? tag(1'b0, b0_addr_q) : {DW{1'b1}};
    rd_data_bank1 <= b1_en_q ? tag(1'b1, b1_addr_q) : {DW{1'b1}};
  end

  // Results of the most recent run_stream call
  int            r_words, r_bad, r_first_bad, r_last_j, r_last_cyc, r_done_cyc;
  int            r_reads, r_both, r_unstable, r_first_valid, r_reads_at_release;
  int            r_reads_in_stall;
  logic          r_busy_at_done, r_busy_first, r_rden_first, r_rst_ok, r_aborted, r_timeout;
  logic [DW-1:0] r_bad_data, r_bad_exp;
  logic          r_rd_bank [3];
  int            r_rd_addr [3];

  // Launches one readout and consumes it. mode 0: ready held high, 1: random
  // ready, 2: ready dropped for 10 cycles once out_valid first rises.
  task automatic run_stream(input logic [1:0] cn, input int mode, input int extra_start_at,
                            input int abort_after, input bit pre_started, input bit chain);
    int n, s, m, cyc, budget, exp_pos;
    bit finished;
    logic prev_stalled, prev_last, exp_last;
    logic [DW-1:0] prev_data, exp_data;
    logic [LOGN-1:0] prev_index;
    n = (cn == 2'd3) ? 2 : int'(cn);
    s = 1 << (LOGN - 3 + n);
    m = 4 * s;
    r_words = 0; r_bad = 0; r_first_bad = -1; r_last_j = -1; r_last_cyc = -1;
    r_done_cyc = -1; r_reads = 0; r_both = 0; r_unstable = 0; r_first_valid = -1;
    r_reads_at_release = -1; r_reads_in_stall = 0; r_busy_at_done = 1'b1;
    r_busy_first = 1'b0; r_rden_first = 1'b0; r_rst_ok = 1'b0; r_aborted = 1'b0;
    r_timeout = 1'b0; r_bad_data = '0; r_bad_exp = '0;
    for (int k = 0; k < 3; k++) begin r_rd_bank[k] = 1'b1; r_rd_addr[k] = -1; end
    exp_pos = 1; prev_stalled = 1'b0; prev_data = '0; prev_index = '0; prev_last = 1'b0;
    budget = 5 * s + 100;
    if (!pre_started) begin
      @(negedge clk);
      current_n = cn;
      start = 1'b1;
    end
    cyc = 0;
    finished = 1'b0;
    while (!finished && cyc < budget) begin
      @(negedge clk);
      cyc++;
      start = (cyc == extra_start_at);
      if (cyc == 1) begin
        r_busy_first = busy;
        r_rden_first = rd_en_bank0 | rd_en_bank1;
      end
      if (out_valid && r_first_valid < 0) r_first_valid = cyc;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 1) == 1);
        default: out_ready = !(r_first_valid >= 0 && cyc < r_first_valid + 10);
      endcase
      if (rd_en_bank0 && rd_en_bank1) r_both++;
      if (rd_en_bank0 || rd_en_bank1) begin
        if (r_reads < 3) begin
          r_rd_bank[r_reads] = rd_en_bank1;
          r_rd_addr[r_reads] = rd_en_bank1 ? int'(rd_addr_bank1) : int'(rd_addr_bank0);
        end
        r_reads++;
        if (mode == 2 && r_first_valid >= 0 && cyc > r_first_valid && cyc < r_first_valid + 10)
          r_reads_in_stall++;
      end
      if (mode == 2 && r_first_valid >= 0 && cyc == r_first_valid + 9) r_reads_at_release = r_reads;
      if (prev_stalled && (out_data !== prev_data || out_index !== prev_index || out_last !== prev_last))
        r_unstable++;
      if (done) begin
        r_done_cyc = cyc;
        r_busy_at_done = busy;
        finished = 1'b1;
        if (chain) begin
          current_n = cn;
          start = 1'b1;
        end
      end
      if (out_valid && out_ready) begin
        exp_data = model_word(n, exp_pos);
        exp_last = (r_words == s - 1);
        if (out_data !== exp_data || out_index !== LOGN'(r_words) || out_last !== exp_last) begin
          if (r_bad == 0) begin
            r_first_bad = r_words;
            r_bad_data = out_data;
            r_bad_exp = exp_data;
          end
          r_bad++;
        end
        if (out_last) begin
          r_last_j = int'(out_index);
          r_last_cyc = cyc;
        end
        r_words++;
        exp_pos = (exp_pos * 3) % m;
      end
      prev_stalled = out_valid && !out_ready;
      prev_data = out_data;
      prev_index = out_index;
      prev_last = out_last;
      if (abort_after > 0 && r_words == abort_after && !finished) begin
        rst = 1'b1;
        #1;
        r_rst_ok = (busy === 1'b0 && done === 1'b0 && rd_en_bank0 === 1'b0 && rd_en_bank1 === 1'b0 &&
                    rd_addr_bank0 === '0 && rd_addr_bank1 === '0 && out_valid === 1'b0 &&
                    out_last === 1'b0 && out_data === '0 && out_index === '0);
        @(negedge clk);
        rst = 1'b0;
        r_aborted = 1'b1;
        finished = 1'b1;
      end
    end
    if (!finished) r_timeout = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; current_n = 2'd2; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if ({rd_en_bank0, rd_en_bank1} !== 2'b00) begin failures++; $display("[TB] FAIL reset_rd_en: got %b%b expected 00", rd_en_bank0, rd_en_bank1); end
    checks++; if (rd_addr_bank0 !== '0 || rd_addr_bank1 !== '0) begin failures++; $display("[TB] FAIL reset_rd_addr: got %0d/%0d expected 0/0", rd_addr_bank0, rd_addr_bank1); end
    checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_flags: got valid=%b last=%b expected 0/0", out_valid, out_last); end
    checks++; if (out_data !== '0 || out_index !== '0) begin failures++; $display("[TB] FAIL reset_out_word: got data=%h index=%0d expected 0/0", out_data, out_index); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_n2();
    run_stream(2'd2, 0, -1, -1, 1'b0, 1'b0);
    checks++; if (r_timeout !== 1'b0) begin failures++; $display("[TB] FAIL full_timeout: got %b expected 0", r_timeout); end
    checks++; if (r_busy_first !== 1'b1 || r_rden_first !== 1'b1) begin failures++; $display("[TB] FAIL full_first_cycle: got busy=%b rd_en=%b expected 1/1", r_busy_first, r_rden_first); end
    checks++; if (r_rd_bank[0] !== 1'b0 || r_rd_addr[0] != 0) begin failures++; $display("[TB] FAIL full_slot0_read: got bank%0d addr %0d expected bank0 addr 0", r_rd_bank[0], r_rd_addr[0]); end
    checks++; if (r_rd_bank[1] !== 1'b0 || r_rd_addr[1] != 2048) begin failures++; $display("[TB] FAIL full_slot1_read: got bank%0d addr %0d expected bank0 addr 2048", r_rd_bank[1], r_rd_addr[1]); end
    checks++; if (r_rd_bank[2] !== 1'b0 || r_rd_addr[2] != 512) begin failures++; $display("[TB] FAIL full_slot2_read: got bank%0d addr %0d expected bank0 addr 512", r_rd_bank[2], r_rd_addr[2]); end
    checks++; if (r_first_valid != 4) begin failures++; $display("[TB] FAIL full_first_valid_cycle: got %0d expected 4", r_first_valid); end
    checks++; if (r_words != 4096) begin failures++; $display("[TB] FAIL full_word_count: got %0d expected 4096", r_words); end
    checks++; if (r_bad != 0) begin failures++; $display("[TB] FAIL full_words_match: got %0d bad (first j=%0d data %h want %h) expected 0", r_bad, r_first_bad, r_bad_data, r_bad_exp); end
    checks++; if (r_last_j != 4095) begin failures++; $display("[TB] FAIL full_last_index: got %0d expected 4095", r_last_j); end
    checks++; if (r_last_cyc != 4099) begin failures++; $display("[TB] FAIL full_no_bubbles: got last handshake cycle %0d expected 4099", r_last_cyc); end
    checks++; if (r_done_cyc != r_last_cyc + 1) begin failures++; $display("[TB] FAIL full_done_timing: got cycle %0d expected %0d", r_done_cyc, r_last_cyc + 1); end
    checks++; if (r_busy_at_done !== 1'b0) begin failures++; $display("[TB] FAIL full_busy_at_done: got %b expected 0", r_busy_at_done); end
    checks++; if (r_both != 0) begin failures++; $display("[TB] FAIL full_both_enables: got %0d cycles expected 0", r_both); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL full_done_pulse_width: got %b expected 0", done); end
  endtask

  task automatic test_small_ring();
    run_stream(2'd0, 0, -1, -1, 1'b0, 1'b0);
    checks++; if (r_words != 1024) begin failures++; $display("[TB] FAIL n0_word_count: got %0d expected 1024", r_words); end
    checks++; if (r_bad != 0) begin failures++; $display("[TB] FAIL n0_words_match: got %0d bad (first j=%0d data %h want %h) expected 0", r_bad, r_first_bad, r_bad_data, r_bad_exp); end
    checks++; if (r_rd_bank[1] !== 1'b0 || r_rd_addr[1] != 512) begin failures++; $display("[TB] FAIL n0_slot1_read: got bank%0d addr %0d expected bank0 addr 512", r_rd_bank[1], r_rd_addr[1]); end
    checks++; if (r_rd_bank[2] !== 1'b0 || r_rd_addr[2] != 128) begin failures++; $display("[TB] FAIL n0_slot2_read: got bank%0d addr %0d expected bank0 addr 128", r_rd_bank[2], r_rd_addr[2]); end
    checks++; if (r_last_j != 1023) begin failures++; $display("[TB] FAIL n0_last_index: got %0d expected 1023", r_last_j); end
    run_stream(2'd3, 0, -1, -1, 1'b0, 1'b0);
    checks++; if (r_words != 4096 || r_bad != 0) begin failures++; $display("[TB] FAIL n3_as_n2: got %0d words %0d bad expected 4096 words 0 bad", r_words, r_bad); end
    checks++; if (r_rd_addr[1] != 2048 || r_last_j != 4095) begin failures++; $display("[TB] FAIL n3_slot1_and_last: got addr %0d last %0d expected 2048 and 4095", r_rd_addr[1], r_last_j); end
  endtask

  task automatic test_backpressure();
    run_stream(2'd2, 2, -1, -1, 1'b0, 1'b0);
    checks++; if (r_first_valid != 4) begin failures++; $display("[TB] FAIL bp_first_valid_cycle: got %0d expected 4", r_first_valid); end
    checks++; if (r_reads_at_release != 4) begin failures++; $display("[TB] FAIL bp_reads_before_release: got %0d expected 4", r_reads_at_release); end
    checks++; if (r_reads_in_stall != 0) begin failures++; $display("[TB] FAIL bp_reads_while_stalled: got %0d expected 0", r_reads_in_stall); end
    checks++; if (r_words != 4096 || r_bad != 0) begin failures++; $display("[TB] FAIL bp_stream: got %0d words %0d bad (first j=%0d) expected 4096 words 0 bad", r_words, r_bad, r_first_bad); end
    checks++; if (r_unstable != 0) begin failures++; $display("[TB] FAIL bp_stable_hold: got %0d changes expected 0", r_unstable); end
  endtask

  task automatic test_random_ready();
    run_stream(2'd0, 1, -1, -1, 1'b0, 1'b0);
    checks++; if (r_timeout !== 1'b0) begin failures++; $display("[TB] FAIL rand_timeout: got %b expected 0", r_timeout); end
    checks++; if (r_words != 1024 || r_bad != 0) begin failures++; $display("[TB] FAIL rand_stream: got %0d words %0d bad (first j=%0d) expected 1024 words 0 bad", r_words, r_bad, r_first_bad); end
    checks++; if (r_both != 0) begin failures++; $display("[TB] FAIL rand_both_enables: got %0d cycles expected 0", r_both); end
    checks++; if (r_unstable != 0) begin failures++; $display("[TB] FAIL rand_stable_hold: got %0d changes expected 0", r_unstable); end
  endtask

  task automatic test_back_to_back();
    run_stream(2'd0, 0, 50, -1, 1'b0, 1'b1);
    checks++; if (r_words != 1024 || r_bad != 0) begin failures++; $display("[TB] FAIL b2b_first_run: got %0d words %0d bad expected 1024 words 0 bad", r_words, r_bad); end
    run_stream(2'd0, 0, -1, -1, 1'b1, 1'b0);
    checks++; if (r_busy_first !== 1'b1) begin failures++; $display("[TB] FAIL b2b_start_at_done: got busy=%b expected 1", r_busy_first); end
    checks++; if (r_words != 1024 || r_bad != 0 || r_timeout !== 1'b0) begin failures++; $display("[TB] FAIL b2b_second_run: got %0d words %0d bad timeout=%b expected 1024 words 0 bad", r_words, r_bad, r_timeout); end
  endtask

  task automatic test_abort();
    run_stream(2'd2, 0, -1, 101, 1'b0, 1'b0);
    checks++; if (r_aborted !== 1'b1 || r_rst_ok !== 1'b1) begin failures++; $display("[TB] FAIL abort_async_reset: got aborted=%b outputs_reset=%b expected 1/1", r_aborted, r_rst_ok); end
    #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("[TB] FAIL abort_idle_after: got busy=%b valid=%b expected 0/0", busy, out_valid); end
    run_stream(2'd2, 0, -1, -1, 1'b0, 1'b0);
    checks++; if (r_rd_addr[0] != 0 || r_rd_addr[1] != 2048) begin failures++; $display("[TB] FAIL abort_replay_reads: got %0d,%0d expected 0,2048", r_rd_addr[0], r_rd_addr[1]); end
    checks++; if (r_words != 4096 || r_bad != 0) begin failures++; $display("[TB] FAIL abort_replay_stream: got %0d words %0d bad (first j=%0d) expected 4096 words 0 bad", r_words, r_bad, r_first_bad); end
  endtask

  initial begin
    $display("[TB] compress_reader bench starting");
    test_reset();
    test_full_n2();
    test_small_ring();
    test_backpressure();
    test_random_ready();
    test_back_to_back();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/compress_reader.md
# compress_reader

Read-side counterpart of the slot-expansion write path: walks the CKKS slot order (powers of 3 modulo M), converts each position to its bit-reversed FFT index, and reads the non-conjugate entry of each slot from the two FFT BRAM banks. The block streams the words to software through a valid/ready interface with backpressure. It sits between the FFT BRAM banks and the software read port after the inverse-embedding FFT has finished.

## Interface
Parameters:
- LOGN, 13, log2 of the full FFT index space. Bank address width is LOGN-1. Internal LOGM = LOGN+1.
- RD_LATENCY, 2, fixed BRAM read latency in cycles, from rd_en to rd_data valid (≥1).
- FIFO_DEPTH, 4, output buffer depth in words. Must be ≥ RD_LATENCY+1; must be a power of 2.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a readout. Ignored while busy.
- current_n  in  2  ring size select, sampled at start. Values 0/1/2; 3 is treated as 2.
- busy  out  1  readout in progress.
- done  out  1  one-cycle pulse after the last output handshake.
- rd_addr_bank0 / rd_addr_bank1  out  LOGN-1  BRAM read addresses.
- rd_en_bank0 / rd_en_bank1  out  1  BRAM read enables. At most one is high per cycle.
- rd_data_bank0 / rd_data_bank1  in  2*`OVERALL_BITS  BRAM read data.
- out_data  out  2*`OVERALL_BITS  slot word, passed unmodified from the bank.
- out_index  out  LOGN  slot number j (0-based) of out_data.
- out_last  out  1  high with the final slot word.
- out_valid  out  1  / out_ready  in  1  stream handshake. Transfer occurs when both are high on a rising edge.

## Operation
- n = min(current_n, 2). M_eff = 2^(LOGM-2+n). Slot count S = M_eff/4.
- Position counter pos (LOGM bits):
  - Set to 1 at start.
  - Advanced by one issued read: pos ← (3·pos) mod M_eff, computed as (pos<<1)+pos, then masked to LOGM-2+n bits.
- Index generation per read:
  - t = (pos-1)>>1, LOGN bits.
  - idx = bitreverse_LOGN(t) >> (2-n).
  - bank = idx[0], addr = idx[LOGN-1:1].
  - Drive rd_en_bank<bank> and rd_addr_bank<bank> = addr. The other bank's enable is low; its address is don't-care (hold 0).
- Read pipeline:
  - A RD_LATENCY-deep shift register carries {valid, bank, slot j, last} alongside each read.
  - When its valid bit emerges, the selected bank's rd_data is pushed into the FIFO together with j and last.
- Credit rule: a read is issued in a cycle only if (reads in flight + FIFO occupancy) < FIFO_DEPTH and issued count < S. The FIFO therefore never overflows and no read is ever dropped.
- FIFO:
  - Outputs come from the FIFO head; out_valid = FIFO non-empty.
  - Order is strictly preserved.
  - out_data, out_index and out_last hold stable while out_valid=1 and out_ready=0.
- State machine:
  - IDLE: start → ISSUE, busy=1.
  - ISSUE: issue reads per the credit rule. After the S-th issue → DRAIN.
  - DRAIN: wait for the handshake with out_last.
  - That handshake → IDLE, with done pulsed in the following cycle and busy cleared in the same cycle as done.
- Boundaries:
  - pos after S advances returns to 1; this is checked by assertion.
  - start while busy is ignored.
  - start coinciding with done is accepted, since busy is already 0 in that cycle.
  - rst asserted mid-run aborts immediately. Any in-flight BRAM data is discarded.

## Timing
- Reset values:
  - busy=0, done=0.
  - rd_en_bank0/1=0, rd_addr_bank0/1=0.
  - out_valid=0, out_last=0, out_data=0, out_index=0.
  - FIFO empty, pos=1.
- start sampled at edge T. busy=1 and the first rd_en are asserted in cycle T+1.
- Data returned at edge T+1+RD_LATENCY is written to the FIFO. out_valid rises in cycle T+2+RD_LATENCY.
- With out_ready held high: one read and one output per cycle, no bubbles. Total run is S+RD_LATENCY+2 cycles to the last handshake; done follows one cycle later.
- out_ready low: issue stalls when credit runs out. Issue resumes in the cycle after a handshake frees a credit.

## Test plan
- LOGN=13, current_n=2, out_ready=1, banks preloaded with data = address tag:
  - reads are slot0→bank0 addr0, slot1→bank0 addr2048, slot2→bank0 addr512;
  - 4096 words out, all matching the software model;
  - out_last on j=4095;
  - done exactly one cycle after the last handshake.
- current_n=0:
  - S=1024; slot1 reads bank0 addr512 (t=1 → 4096>>2=1024);
  - pos returns to 1 after 1024 issues;
  - current_n=3 gives the same results as current_n=2.
- Backpressure, RD_LATENCY=2, FIFO_DEPTH=4:
  - hold out_ready=0 for 10 cycles after out_valid rises;
  - exactly 4 reads are issued, then rd_en stays low;
  - on release the stream resumes with no loss, duplication or reordering.
- Random out_ready (50%):
  - all words match the model in order;
  - rd_en_bank0 and rd_en_bank1 are never high together;
  - out_data is stable while stalled.
- Pulse start while busy:
  - the pulse is ignored and the word count stays S;
  - start in the same cycle as done launches a second full run.
- Assert rst mid-run (after slot 100) for one cycle:
  - all outputs return to reset values asynchronously;
  - a fresh start then replays from slot 0 with correct data.
